// File: rtl/mips_arb_pkg.sv
// Shared types and constants for the MIPS memory-port arbiter.
package mips_arb_pkg;
  localparam int ARB_DATA_W = 32;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;

  typedef enum logic {IDLE, WAIT} arb_state_t;
endpackage

// File: rtl/arb_pick2.sv
// Combinational two-way winner pick. ARB_ROUND_ROBIN_EN selects round-robin
// tie-break on last_gnt; otherwise load/store wins every tie.
import mips_arb_pkg::*;

module arb_pick2 (
  input  logic req_0,
  input  logic req_1,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic last_gnt,
`endif
  output logic gnt
);
  always_comb begin
    gnt = REQ_IF;
    if (req_1 && !req_0) begin
      gnt = REQ_LS;
    end else if (req_0 && req_1) begin
`ifdef ARB_ROUND_ROBIN_EN
      gnt = ~last_gnt;
`else
      gnt = REQ_LS;
`endif
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (0) and load/store (1) with a
// req/ready handshake and timeout abort. Tie policy set by ARB_ROUND_ROBIN_EN.
import mips_arb_pkg::*;

module mem_port_arbiter #(
  parameter int DATA_W  = ARB_DATA_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_0,
  input  logic              req_1,
  input  logic [DATA_W-1:0] addr_0,
  input  logic [DATA_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_0,
  input  logic [DATA_W-1:0] wdata_1,
  input  logic              we_0,
  input  logic              we_1,
  output logic              sel,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata,
  output logic              done_0,
  output logic              done_1,
  output logic              err_0,
  output logic              err_1
);
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  arb_state_t state;
  logic [7:0] cnt;
  logic       gnt;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_gnt;

  arb_pick2 u_pick (
    .req_0    (req_0),
    .req_1    (req_1),
    .last_gnt (last_gnt),
    .gnt      (gnt)
  );
`else
  arb_pick2 u_pick (
    .req_0 (req_0),
    .req_1 (req_1),
    .gnt   (gnt)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= REQ_IF;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      rdata     <= '0;
      done_0    <= 1'b0;
      done_1    <= 1'b0;
      err_0     <= 1'b0;
      err_1     <= 1'b0;
      cnt       <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_gnt  <= REQ_LS;
`endif
    end else begin
      done_0 <= 1'b0;
      done_1 <= 1'b0;
      err_0  <= 1'b0;
      err_1  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_0 || req_1) begin
            sel       <= gnt;
            mem_addr  <= (gnt == REQ_LS) ? addr_1  : addr_0;
            mem_wdata <= (gnt == REQ_LS) ? wdata_1 : wdata_0;
            mem_we    <= (gnt == REQ_LS) ? we_1    : we_0;
            mem_req   <= 1'b1;
            cnt       <= '0;
            state     <= WAIT;
`ifdef ARB_ROUND_ROBIN_EN
            last_gnt  <= gnt;
`endif
          end
        end
        WAIT: begin
          // A ready on the final timeout cycle still counts as a completion.
          if (mem_ready) begin
            rdata   <= mem_rdata;
            done_0  <= (sel == REQ_IF);
            done_1  <= (sel == REQ_LS);
            mem_req <= 1'b0;
            state   <= IDLE;
          end else if (cnt == TO_LIM) begin
            rdata   <= '0;
            done_0  <= (sel == REQ_IF);
            done_1  <= (sel == REQ_LS);
            err_0   <= (sel == REQ_IF);
            err_1   <= (sel == REQ_LS);
            mem_req <= 1'b0;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle table plus tie, timeout and
// mid-transaction reset sequences. Tie expectations follow ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_0, req_1, we_0, we_1, mem_ready;
  logic [31:0] addr_0, addr_1, wdata_0, wdata_1, mem_rdata;
  logic        sel, mem_req, mem_we, done_0, done_1, err_0, err_1;
  logic [31:0] mem_addr, mem_wdata, rdata;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_W(32), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_0     (req_0),
    .req_1     (req_1),
    .addr_0    (addr_0),
    .addr_1    (addr_1),
    .wdata_0   (wdata_0),
    .wdata_1   (wdata_1),
    .we_0      (we_0),
    .we_1      (we_1),
    .sel       (sel),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .rdata     (rdata),
    .done_0    (done_0),
    .done_1    (done_1),
    .err_0     (err_0),
    .err_1     (err_1)
  );

  typedef struct {
    string       nm;
    logic        r0;  logic [31:0] a0; logic [31:0] w0; logic we0;
    logic        r1;  logic [31:0] a1; logic [31:0] w1; logic we1;
    logic        rdy; logic [31:0] rd;
    logic        e_sel; logic e_req; logic [31:0] e_addr; logic [31:0] e_wdata; logic e_we;
    logic        e_d0; logic e_d1; logic e_e0; logic e_e1; logic [31:0] e_rdata;
  } vec_t;

  vec_t vec[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %b, expected %b", nm, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    req_0 = 1'b0; req_1 = 1'b0; we_0 = 1'b0; we_1 = 1'b0; mem_ready = 1'b0;
    addr_0 = '0; addr_1 = '0; wdata_0 = '0; wdata_1 = '0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic eg;
    //          name      r0   a0        w0      we0   r1   a1      w1      we1   rdy  rd
    //          sel  req  addr      wdata   we    d0    d1    e0    e1    rdata
    vec[0]  = '{"idle",      1'b0, 32'h0,   32'h0,  1'b0, 1'b0, 32'h0,  32'h0,  1'b0, 1'b0, 32'h0,
                1'b0, 1'b0, 32'h0,   32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vec[1]  = '{"grant0",    1'b1, 32'h100, 32'h11, 1'b0, 1'b0, 32'h0,  32'h0,  1'b0, 1'b0, 32'h0,
                1'b0, 1'b1, 32'h100, 32'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vec[2]  = '{"wait0",     1'b1, 32'h999, 32'h22, 1'b1, 1'b0, 32'h0,  32'h0,  1'b0, 1'b0, 32'h0,
                1'b0, 1'b1, 32'h100, 32'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vec[3]  = '{"done0",     1'b1, 32'h999, 32'h22, 1'b1, 1'b0, 32'h0,  32'h0,  1'b0, 1'b1, 32'hDEADBEEF,
                1'b0, 1'b0, 32'h100, 32'h11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF};
    vec[4]  = '{"idle0",     1'b0, 32'h0,   32'h0,  1'b0, 1'b0, 32'h0,  32'h0,  1'b0, 1'b0, 32'h0,
                1'b0, 1'b0, 32'h100, 32'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF};
    vec[5]  = '{"grant1",    1'b0, 32'h0,   32'h0,  1'b0, 1'b1, 32'h44, 32'h55, 1'b1, 1'b1, 32'hBAD,
                1'b1, 1'b1, 32'h44,  32'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF};
    vec[6]  = '{"done1",     1'b0, 32'h0,   32'h0,  1'b0, 1'b0, 32'h66, 32'h0,  1'b0, 1'b1, 32'h12345678,
                1'b1, 1'b0, 32'h44,  32'h55, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h12345678};
    vec[7]  = '{"idle_hold", 1'b0, 32'h0,   32'h0,  1'b0, 1'b0, 32'h0,  32'h0,  1'b0, 1'b0, 32'h0,
                1'b1, 1'b0, 32'h44,  32'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h12345678};
    vec[8]  = '{"grant0b",   1'b1, 32'h8,   32'h77, 1'b0, 1'b0, 32'h0,  32'h0,  1'b0, 1'b0, 32'h0,
                1'b0, 1'b1, 32'h8,   32'h77, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h12345678};
    vec[9]  = '{"wait0b",    1'b1, 32'h8,   32'h77, 1'b0, 1'b0, 32'h0,  32'h0,  1'b0, 1'b0, 32'h0,
                1'b0, 1'b1, 32'h8,   32'h77, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h12345678};
    vec[10] = '{"done0b",    1'b1, 32'h8,   32'h77, 1'b0, 1'b0, 32'h0,  32'h0,  1'b0, 1'b1, 32'hA5,
                1'b0, 1'b0, 32'h8,   32'h77, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hA5};
    vec[11] = '{"idle_b",    1'b0, 32'h0,   32'h0,  1'b0, 1'b0, 32'h0,  32'h0,  1'b0, 1'b0, 32'h0,
                1'b0, 1'b0, 32'h8,   32'h77, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hA5};

    rst_n = 1'b0;
    clr_inputs();
    #1;
    chkb("rst_mem_req", mem_req, 1'b0);
    chkb("rst_sel", sel, 1'b0);
    chk ("rst_rdata", rdata, 32'h0);
    do_reset();

    for (int i = 0; i < 12; i++) begin
      req_0 = vec[i].r0; addr_0 = vec[i].a0; wdata_0 = vec[i].w0; we_0 = vec[i].we0;
      req_1 = vec[i].r1; addr_1 = vec[i].a1; wdata_1 = vec[i].w1; we_1 = vec[i].we1;
      mem_ready = vec[i].rdy; mem_rdata = vec[i].rd;
      tick();
      chkb({vec[i].nm, ".sel"},     sel,       vec[i].e_sel);
      chkb({vec[i].nm, ".mem_req"}, mem_req,   vec[i].e_req);
      chk ({vec[i].nm, ".addr"},    mem_addr,  vec[i].e_addr);
      chk ({vec[i].nm, ".wdata"},   mem_wdata, vec[i].e_wdata);
      chkb({vec[i].nm, ".we"},      mem_we,    vec[i].e_we);
      chkb({vec[i].nm, ".done_0"},  done_0,    vec[i].e_d0);
      chkb({vec[i].nm, ".done_1"},  done_1,    vec[i].e_d1);
      chkb({vec[i].nm, ".err_0"},   err_0,     vec[i].e_e0);
      chkb({vec[i].nm, ".err_1"},   err_1,     vec[i].e_e1);
      chk ({vec[i].nm, ".rdata"},   rdata,     vec[i].e_rdata);
    end

    // Both requesters held with a zero-wait memory, starting from reset.
    do_reset();
    req_0 = 1'b1; req_1 = 1'b1; addr_0 = 32'h1000; addr_1 = 32'h2000;
    mem_ready = 1'b1; mem_rdata = 32'hCAFE;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      eg = (k % 2 == 1);
`else
      eg = 1'b1;
`endif
      tick();
      chkb("tie_sel", sel, eg);
      chkb("tie_req_hi", mem_req, 1'b1);
      chk ("tie_addr", mem_addr, eg ? 32'h2000 : 32'h1000);
      tick();
      chkb("tie_done0", done_0, ~eg);
      chkb("tie_done1", done_1, eg);
      chkb("tie_req_lo", mem_req, 1'b0);
    end
    clr_inputs();
    tick();
    chk("tie_rdata_held", rdata, 32'hCAFE);

    // Timeout on a load/store write.
    req_1 = 1'b1; we_1 = 1'b1; addr_1 = 32'h200; wdata_1 = 32'd50;
    tick();
    chkb("to_req", mem_req, 1'b1);
    chkb("to_sel", sel, 1'b1);
    chkb("to_we", mem_we, 1'b1);
    chk ("to_wdata", mem_wdata, 32'd50);
    req_1 = 1'b0; we_1 = 1'b0;
    for (int i = 0; i < TO; i++) begin
      tick();
      chkb("to_no_done", done_1, 1'b0);
      chkb("to_req_held", mem_req, 1'b1);
    end
    tick();
    chkb("to_done1", done_1, 1'b1);
    chkb("to_err1", err_1, 1'b1);
    chkb("to_err0", err_0, 1'b0);
    chk ("to_rdata", rdata, 32'h0);
    chkb("to_req_lo", mem_req, 1'b0);
    tick();
    chkb("to_err_pulse", err_1, 1'b0);

    // Ready arriving on the last allowed cycle beats the timeout.
    req_0 = 1'b1; addr_0 = 32'h10;
    tick();
    req_0 = 1'b0;
    for (int i = 0; i < TO; i++) tick();
    chkb("rt_still_wait", mem_req, 1'b1);
    mem_ready = 1'b1; mem_rdata = 32'd100;
    tick();
    chkb("rt_done0", done_0, 1'b1);
    chkb("rt_err0", err_0, 1'b0);
    chk ("rt_rdata", rdata, 32'd100);
    mem_ready = 1'b0;

    // Reset in the middle of a transaction.
    req_1 = 1'b1; we_1 = 1'b1; addr_1 = 32'h300; wdata_1 = 32'h9;
    tick();
    chkb("mr_req", mem_req, 1'b1);
    req_1 = 1'b0;
    rst_n = 1'b0;
    #1;
    chkb("mr_req0", mem_req, 1'b0);
    chkb("mr_sel0", sel, 1'b0);
    chk ("mr_addr0", mem_addr, 32'h0);
    chk ("mr_wdata0", mem_wdata, 32'h0);
    chkb("mr_we0", mem_we, 1'b0);
    chk ("mr_rdata0", rdata, 32'h0);
    mem_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    mem_ready = 1'b0;
    tick();
    chkb("mr_no_done1", done_1, 1'b0);
    chkb("mr_idle", mem_req, 1'b0);
    req_0 = 1'b1; addr_0 = 32'h304;
    tick();
    chkb("mr_new_req", mem_req, 1'b1);
    chk ("mr_new_addr", mem_addr, 32'h304);
    mem_ready = 1'b1; mem_rdata = 32'hBEEF;
    tick();
    chkb("mr_new_done0", done_0, 1'b1);
    chk ("mr_new_rdata", rdata, 32'hBEEF);
    clr_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one 32-bit memory port between the instruction-fetch path (requester 0) and the load/store path (requester 1) of the MIPS core. It latches the winning requester's address, write data and write enable. It drives the select line of the shared 32-bit 2:1 address/data mux and tracks the memory transaction with a req/ready handshake and a timeout. It returns read data with a per-requester completion pulse.

## Interface
- DATA_W, 32, data and address width
- TIMEOUT, 15, maximum WAIT cycles without mem_ready before abort (1..255)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_0 / req_1  in  1  transaction request; held until matching done
- addr_0 / addr_1  in  DATA_W  byte address
- wdata_0 / wdata_1  in  DATA_W  write data
- we_0 / we_1  in  1  1 = write, 0 = read
- sel  out  1  mux select: 0 = requester 0 owns port, 1 = requester 1
- mem_req  out  1  memory request, high for entire transaction
- mem_addr  out  DATA_W  registered address of granted requester
- mem_wdata  out  DATA_W  registered write data
- mem_we  out  1  registered write enable
- mem_ready  in  1  memory completion, sampled while mem_req high
- mem_rdata  in  DATA_W  read data, valid with mem_ready
- rdata  out  DATA_W  captured read data, held until next completion
- done_0 / done_1  out  1  one-cycle completion pulse
- err_0 / err_1  out  1  one-cycle timeout pulse, coincident with done

## Operation
- Two states: IDLE and WAIT.
- IDLE, no request: all pulses low, mem_req low.
- IDLE, request present: pick a winner, register addr/wdata/we, set sel, assert mem_req, clear timeout counter, go to WAIT.
- Winner, only one req high: that requester.
- Winner, both high: the requester not granted last (last_gnt register, updated on every grant).
- WAIT, mem_ready high:
  - capture mem_rdata into rdata (writes also capture it; don't-care)
  - pulse done_k for the owner
  - drop mem_req, go to IDLE
- WAIT, mem_ready low: increment counter.
- WAIT, counter reaches TIMEOUT:
  - pulse done_k and err_k
  - rdata <= 0
  - drop mem_req, go to IDLE
- mem_ready and timeout in the same cycle: mem_ready wins, no err.
- req_k dropped during WAIT: transaction still completes and done_k still pulses; the requester ignores it.
- Requester inputs are don't-care after grant; they are not re-sampled.
- mem_ready while mem_req low: ignored.
- sel changes only on a grant in IDLE; it holds its value while in IDLE.

## Timing
- Reset values: state IDLE, sel 0, mem_req 0, mem_addr/mem_wdata/rdata 0, mem_we 0, done/err 0, last_gnt 1 (requester 0 wins the first tie), counter 0.
- Request seen in IDLE at cycle N:
  - mem_req, sel, mem_addr, mem_we valid from N+1
  - mem_ready high at cycle M (M ≥ N+1): done_k and rdata valid at M+1, mem_req low at M+1
- Zero-wait memory: request at N, done at N+2.
- One mandatory IDLE cycle between transactions; maximum throughput is 1 per 2 cycles.
- Timeout: err_k at N+1+TIMEOUT+1 when mem_ready never arrives.
- Reset assertion mid-WAIT: immediate return to reset values; no done pulse.

## Configuration
- ARB_ROUND_ROBIN_EN defined: tie-break uses last_gnt as described above.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 1 (load/store) always wins ties. last_gnt is not implemented.
- All other behaviour is identical in both builds.

## Structure
- Package mips_arb_pkg holds:
  - state typedef (IDLE, WAIT)
  - DATA_W default
  - requester index constants REQ_IF = 0, REQ_LS = 1
- Sub-module arb_pick2: combinational winner selection from req_0, req_1 and last_gnt, with the ARB_ROUND_ROBIN_EN variant inside it.
- Timeout counter and datapath registers stay in the top module.

## Test plan
- Single read: req_0, addr_0=0x100, mem_ready one cycle after mem_req with mem_rdata=0xDEADBEEF -> sel=0, mem_addr=0x100, done_0 and rdata=0xDEADBEEF 2 cycles after mem_req rose.
- Simultaneous reqs, round-robin build: req_0 and req_1 held high for 4 transactions, zero-wait memory -> grants 0,1,0,1; sel toggles; done pulses alternate.
- Same stimulus, fixed-priority build: -> requester 1 granted every time; done_0 never pulses.
- Timeout: req_1 write, addr_1=0x200, wdata_1=50, mem_ready held low -> done_1 and err_1 together TIMEOUT+1 cycles after mem_req rose; rdata=0; mem_req low.
- Ready on the timeout cycle: mem_ready asserted on counter=TIMEOUT with mem_rdata=100 -> done pulses, err stays 0, rdata=100.
- Reset mid-WAIT: rst_n low for 1 cycle during WAIT -> all outputs 0 immediately; no done; a fresh req_0 is serviced normally afterward.
